// File: rtl/imul_wb_queue.sv
// Multiplier writeback queue: a valid/tag pipeline that tracks multiplier latency, a result FIFO, and a req/gnt drain.
// Optional macro IMUL_WBQ_BYPASS_EN: when the FIFO is empty, a result goes straight to the writeback port.
module imul_wb_queue #(
    parameter int LAT   = 3,
    parameter int DEPTH = 4,
    parameter int TAGW  = 9
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue_en,
    input  logic [TAGW-1:0]              issue_tag,
    input  logic                         issue_flgen,
    input  logic                         cancel,
    input  logic [64:0]                  mul_res,
    input  logic [5:0]                   mul_flg,
    output logic                         mul_clkEn,
    output logic                         wb_req,
    input  logic                         wb_gnt,
    output logic [64:0]                  wb_data,
    output logic [5:0]                   wb_flg,
    output logic [TAGW-1:0]              wb_tag,
    output logic                         wb_flgen,
    output logic [$clog2(DEPTH+1)-1:0]   occ
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [64:0]     res;
        logic [5:0]      flg;
        logic [TAGW-1:0] tag;
        logic            flgen;
    } wb_ent_t;

    logic [LAT-1:0]            vld_pipe;
    logic [LAT-1:0][TAGW-1:0]  tag_pipe;
    logic [LAT-1:0]            flgen_pipe;

    wb_ent_t         mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [OW-1:0]   cnt;

    logic    v_last;
    logic    full;
    logic    empty;
    logic    push;
    logic    wr_en;
    logic    deq;
    wb_ent_t push_ent;
    wb_ent_t head_ent;

    assign v_last = vld_pipe[LAT-1];
    assign full   = (cnt == OW'(DEPTH));
    assign empty  = (cnt == '0);

    // Only registered state feeds the enable, so a late wb_gnt never reaches the multiplier.
    assign mul_clkEn = ~rst & (~v_last | ~full);
    assign push      = mul_clkEn & v_last;
    assign push_ent  = '{res: mul_res, flg: mul_flg,
                         tag: tag_pipe[LAT-1], flgen: flgen_pipe[LAT-1]};

    // deq only ever retires a stored entry; a bypassed result never enters the FIFO.
    assign deq = wb_gnt & ~empty & ~cancel;

`ifdef IMUL_WBQ_BYPASS_EN
    logic byp;
    assign byp      = empty & push & ~cancel;
    assign wb_req   = ~empty | byp;
    assign head_ent = byp ? push_ent : mem[rd_ptr];
    assign wr_en    = push & ~cancel & ~(byp & wb_gnt);
`else
    assign wb_req   = ~empty;
    assign head_ent = mem[rd_ptr];
    assign wr_en    = push & ~cancel;
`endif

    always_comb begin
        wb_data  = '0;
        wb_flg   = '0;
        wb_tag   = '0;
        wb_flgen = 1'b0;
        if (wb_req) begin
            wb_data  = head_ent.res;
            wb_flg   = head_ent.flg;
            wb_tag   = head_ent.tag;
            wb_flgen = head_ent.flgen;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cancel) begin
            vld_pipe <= '0;
        end else if (mul_clkEn) begin
            vld_pipe[0] <= issue_en;
            for (int i = 1; i < LAT; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    // Tag/flgen payload is qualified by vld_pipe, so it needs no reset.
    always_ff @(posedge clk) begin
        if (mul_clkEn) begin
            tag_pipe[0]   <= issue_tag;
            flgen_pipe[0] <= issue_flgen;
            for (int i = 1; i < LAT; i++) begin
                tag_pipe[i]   <= tag_pipe[i-1];
                flgen_pipe[i] <= flgen_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cancel) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (deq)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, deq})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= push_ent;
    end

    assign occ = cnt;

endmodule

// File: tb/tb_imul_wb_queue.sv
// Directed bench for imul_wb_queue: a queue-level model is checked every cycle, plus literal checks per scenario.
module tb_imul_wb_queue;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;
    localparam int TAGW  = 9;
    localparam int OW    = $clog2(DEPTH+1);
`ifdef IMUL_WBQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst, issue_en, issue_flgen, cancel, wb_gnt;
    logic [TAGW-1:0] issue_tag, wb_tag;
    logic [64:0]     mul_res, wb_data;
    logic [5:0]      mul_flg, wb_flg;
    logic            mul_clkEn, wb_req, wb_flgen;
    logic [OW-1:0]   occ;

    imul_wb_queue #(.LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst), .issue_en(issue_en), .issue_tag(issue_tag),
        .issue_flgen(issue_flgen), .cancel(cancel), .mul_res(mul_res),
        .mul_flg(mul_flg), .mul_clkEn(mul_clkEn), .wb_req(wb_req),
        .wb_gnt(wb_gnt), .wb_data(wb_data), .wb_flg(wb_flg), .wb_tag(wb_tag),
        .wb_flgen(wb_flgen), .occ(occ)
    );

    always #5 clk = ~clk;

    // Model: ops in flight carry an age (enabled edges since issue); the FIFO is a plain queue.
    typedef struct {
        logic [TAGW-1:0] tag;
        logic            flgen;
        int              age;
    } fly_t;
    typedef struct {
        logic [64:0]     res;
        logic [5:0]      flg;
        logic [TAGW-1:0] tag;
        logic            flgen;
    } ent_t;

    fly_t            fly[$];
    ent_t            fifo[$];
    logic [TAGW-1:0] pend[$];
    logic [TAGW-1:0] ret_log[$];
    int              n_chk = 0;
    int              n_pass = 0;
    int              gnt_mode;
    logic            gnt_tog;
    logic            exp_req_s;
    logic            dut_ret;
    logic [TAGW-1:0] dut_ret_tag;

    function automatic logic [64:0] res_of(logic [TAGW-1:0] t);
        logic [31:0] lo;
        lo = 32'(t) * 32'd8 + 32'd2;
        return {t[0], 32'h0, lo};
    endfunction

    function automatic logic [5:0] flg_of(logic [TAGW-1:0] t);
        return t[5:0] * 6'd3 + 6'd1;
    endfunction

    function automatic logic vlast();
        return (fly.size() != 0) && (fly[0].age == LAT-1);
    endfunction

    function automatic logic m_clken();
        return !rst && !(vlast() && fifo.size() >= DEPTH);
    endfunction

    task automatic chk(string nm, logic [64:0] act, logic [64:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive();
        issue_en = 1'b0; issue_tag = '0; issue_flgen = 1'b0;
        if (!rst && !cancel && pend.size() != 0 && m_clken()) begin
            issue_tag   = pend.pop_front();
            issue_en    = 1'b1;
            issue_flgen = issue_tag[1];
        end
        wb_gnt = (gnt_mode == 2) ? gnt_tog : (gnt_mode == 1);
        if (vlast()) begin
            mul_res = res_of(fly[0].tag);
            mul_flg = flg_of(fly[0].tag);
        end else begin
            mul_res = 65'hDEAD_BEEF_0BAD_F00D;
            mul_flg = 6'h2A;
        end
    endtask

    task automatic compare();
        ent_t e;
        logic push, byp;
        #2;
        chk("mul_clkEn", mul_clkEn, m_clken());
        if (issue_en) chk("issue_contract", mul_clkEn, 1);
        exp_req_s = 1'b0;
        dut_ret = 1'b0;
        if (!rst) begin
            push = m_clken() && vlast();
            byp  = BYP && !cancel && push && fifo.size() == 0;
            if (fifo.size() != 0) e = fifo[0];
            else if (byp) e = '{res_of(fly[0].tag), flg_of(fly[0].tag), fly[0].tag, fly[0].flgen};
            else e = '{65'h0, 6'h0, '0, 1'b0};
            exp_req_s = (fifo.size() != 0) || byp;
            chk("wb_req", wb_req, exp_req_s);
            chk("wb_data", wb_data, e.res);
            chk("wb_flg", wb_flg, e.flg);
            chk("wb_tag", wb_tag, e.tag);
            chk("wb_flgen", wb_flgen, e.flgen);
            chk("occ", occ, fifo.size());
            dut_ret = wb_req && wb_gnt && !cancel;
            dut_ret_tag = wb_tag;
        end
    endtask

    task automatic advance();
        ent_t e;
        logic en, push, pop, byp_take;
        @(posedge clk);
        if (dut_ret) ret_log.push_back(dut_ret_tag);
        if (rst || cancel) begin
            fly.delete();
            fifo.delete();
        end else begin
            en   = m_clken();
            push = en && vlast();
            pop  = exp_req_s && wb_gnt;
            byp_take = pop && fifo.size() == 0;
            if (push) begin
                e = '{res_of(fly[0].tag), flg_of(fly[0].tag), fly[0].tag, fly[0].flgen};
                void'(fly.pop_front());
            end
            if (pop && !byp_take) void'(fifo.pop_front());
            if (push && !byp_take) fifo.push_back(e);
            if (en) begin
                foreach (fly[i]) fly[i].age++;
                if (issue_en) fly.push_back('{issue_tag, issue_flgen, 0});
            end
        end
        gnt_tog = !gnt_tog;
        @(negedge clk);
    endtask

    task automatic tick();
        drive(); compare(); advance();
    endtask

    task automatic chk_log(string nm, int base, int n);
        chk({nm, "_count"}, 65'(ret_log.size()), 65'(n));
        for (int i = 0; i < n && i < ret_log.size(); i++)
            chk({nm, "_order"}, 65'(ret_log[i]), 65'(base + i));
    endtask

    initial begin
        rst = 1'b1; cancel = 1'b0; gnt_mode = 0; gnt_tog = 1'b0;
        issue_en = 1'b0; issue_tag = '0; issue_flgen = 1'b0; wb_gnt = 1'b0;
        mul_res = '0; mul_flg = '0; exp_req_s = 1'b0; dut_ret = 1'b0; dut_ret_tag = '0;
        @(negedge clk);
        repeat (2) tick();
        rst = 1'b0;
        drive(); compare();
        chk("rst_clkEn", mul_clkEn, 1);
        chk("rst_wb_req", wb_req, 0);
        chk("rst_occ", occ, 0);
        chk("rst_wb_data", wb_data, 0);
        advance();

        // single op, tag 5 issued at relative cycle 10
        gnt_mode = 1;
        for (int c = 0; c < 16; c++) begin
            if (c == 10) pend.push_back(9'h05);
            drive(); compare();
`ifdef IMUL_WBQ_BYPASS_EN
            if (c == 13) begin
                chk("single_req", wb_req, 1);
                chk("single_data", wb_data, 65'h1_0000_0000_0000_002A);
                chk("single_tag", wb_tag, 9'h05);
            end
            if (c == 14) chk("single_occ", occ, 0);
`else
            if (c == 14) begin
                chk("single_req", wb_req, 1);
                chk("single_data", wb_data, 65'h1_0000_0000_0000_002A);
                chk("single_tag", wb_tag, 9'h05);
            end
            if (c == 15) begin
                chk("single_occ", occ, 0);
                chk("single_req_off", wb_req, 0);
            end
`endif
            advance();
        end

        // back-pressure: tags 1..8, grant withheld until cycle 10
        ret_log.delete(); gnt_mode = 0;
        for (int t = 1; t <= 8; t++) pend.push_back(TAGW'(t));
        for (int c = 0; c < 30; c++) begin
            if (c == 10) gnt_mode = 1;
            drive(); compare();
            if (c == 7) begin
                chk("bp_clkEn", mul_clkEn, 0);
                chk("bp_occ", occ, 4);
                chk("bp_vlast_tag", 65'(fly[0].tag), 65'd5);
            end
            advance();
        end
        chk_log("bp", 1, 8);

        // simultaneous push/pop at occ=2
        ret_log.delete(); gnt_mode = 0;
        for (int t = 16; t <= 18; t++) pend.push_back(TAGW'(t));
        for (int c = 0; c < 15; c++) begin
            if (c == 5) gnt_mode = 1;
            drive(); compare();
            if (c == 5) begin
                chk("pp_occ_before", occ, 2);
                chk("pp_head_before", wb_tag, 16);
            end
            if (c == 6) begin
                chk("pp_occ_after", occ, 2);
                chk("pp_head_after", wb_tag, 17);
            end
            advance();
        end

        // pointer wrap with toggling grant
        ret_log.delete(); gnt_mode = 2; gnt_tog = 1'b1;
        for (int t = 0; t < 11; t++) pend.push_back(TAGW'(32 + t));
        repeat (45) tick();
        chk_log("wrap", 32, 11);

        // cancel at occ=3 with two ops in flight and grant high
        ret_log.delete(); gnt_mode = 0;
        for (int t = 48; t <= 52; t++) pend.push_back(TAGW'(t));
        repeat (6) tick();
        cancel = 1'b1; gnt_mode = 1;
        drive(); compare();
        chk("cancel_occ_before", occ, 3);
        chk("cancel_inflight", 65'(fly.size()), 65'd2);
        advance();
        cancel = 1'b0;
        drive(); compare();
        chk("cancel_req_after", wb_req, 0);
        chk("cancel_occ_after", occ, 0);
        advance();
        chk("cancel_no_retire", 65'(ret_log.size()), 65'd0);
        pend.push_back(9'h03F);
        repeat (10) tick();
        chk_log("post_cancel", 63, 1);

        // reset for one cycle mid-stream with occ=2
        ret_log.delete(); gnt_mode = 0;
        pend.push_back(9'h040); pend.push_back(9'h041);
        repeat (5) tick();
        rst = 1'b1;
        drive(); compare();
        chk("midrst_clkEn", mul_clkEn, 0);
        advance();
        rst = 1'b0;
        drive(); compare();
        chk("midrst_req", wb_req, 0);
        chk("midrst_data", wb_data, 0);
        chk("midrst_flg", wb_flg, 0);
        chk("midrst_tag", wb_tag, 0);
        chk("midrst_flgen", wb_flgen, 0);
        chk("midrst_occ", occ, 0);
        chk("midrst_clkEn_after", mul_clkEn, 1);
        advance();
        gnt_mode = 1;
        pend.push_back(9'h042);
        repeat (8) tick();
        chk_log("post_rst", 66, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
